// File: rtl/card_punch_if.sv
// -----------------------------------------------------------------------------
// card_punch_if
// Bundles every non-clock/reset signal of the card punch: the arbiter device
// port (request/grant, address, read data and the unused write path), the
// CPU-side sio/tio/cc control, and the outgoing valid/ready byte stream.
//
// Modports:
//   master - the card_punch device side (drives request, address, cc, stream)
//   slave  - the environment side (arbiter/memory, CPU, punch/printer sink)
//
// Bit numbering follows the host machine: bit 0 is the most significant bit.
// -----------------------------------------------------------------------------
interface card_punch_if;
  // Arbiter / memory device port
  logic         running;
  logic         active;
  logic [0:31]  memory_data_in;
  logic [15:31] address;
  logic [0:31]  data_out;
  logic [0:3]   wr_en;
  // CPU control
  logic [15:31] io_address;
  logic [0:7]   io_count;
  logic         sio;
  logic         tio;
  logic [0:3]   cc;
  // Byte stream to the punch/printer model
  logic [0:7]   out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output running, address, data_out, wr_en, cc, out_data, out_valid,
    input  active, memory_data_in, io_address, io_count, sio, tio, out_ready
  );

  modport slave (
    input  running, address, data_out, wr_en, cc, out_data, out_valid,
    output active, memory_data_in, io_address, io_count, sio, tio, out_ready
  );
endinterface

// File: rtl/card_punch.sv
// -----------------------------------------------------------------------------
// card_punch
// Read-direction DMA output device. An accepted sio latches a start word
// address and a byte count; the device then bus-masters through the arbiter,
// reads words from memory and serializes each one as big-endian bytes onto a
// valid/ready byte stream. Status is reported with the sio/tio/cc convention
// shared with the card reader. The device never writes memory.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-low reset
//   bus    - card_punch_if.master: arbiter port (running/active/address/
//            memory_data_in/data_out/wr_en), CPU control (io_address/io_count/
//            sio/tio/cc) and byte stream (out_data/out_valid/out_ready)
//
// Parameters:
//   CARD_BYTES - byte count used when io_count is 0
//
// Configuration macro:
//   CARD_PUNCH_PREFETCH_EN - adds a second word register so the next word is
//   fetched while the current one is being shifted out. Undefined: single
//   buffer, request and stream valid are never high together.
// -----------------------------------------------------------------------------
module card_punch #(
  parameter int unsigned CARD_BYTES = 80
) (
  input  logic         clock,
  input  logic         reset,
  card_punch_if.master bus
);

  localparam logic [8:0] CARD_BYTES_9 = 9'(CARD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t       state_r;
  logic [15:31] address_r;
  logic [0:31]  hold_r;
  logic [1:0]   byte_idx_r;
  logic [8:0]   remaining_r;
  logic         done_r;
  logic         running_r;
  logic         out_valid_r;
  logic [0:7]   out_data_r;
  logic [0:3]   cc_r;

`ifdef CARD_PUNCH_PREFETCH_EN
  logic [0:31]  next_r;
  logic         next_valid_r;
  logic         need_more_s;
`endif

  logic         handshake_s;
  logic         grant_s;
  logic         last_s;
  logic         busy_s;
  logic [8:0]   start_count_s;

  // Byte i of a word, with byte 0 taken from the most significant end.
  function automatic logic [0:7] byte_sel(input logic [0:31] word, input logic [1:0] idx);
    logic [0:7] b;
    case (idx)
      2'd0:    b = word[0:7];
      2'd1:    b = word[8:15];
      2'd2:    b = word[16:23];
      2'd3:    b = word[24:31];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Handshake, grant and bookkeeping decodes from the current registers.
  always_comb begin
    handshake_s = out_valid_r & bus.out_ready;
    grant_s     = running_r & bus.active;
    last_s      = (remaining_r == 9'd1);
    busy_s      = (state_r != ST_IDLE);
    if (bus.io_count == 8'd0) begin
      start_count_s = CARD_BYTES_9;
    end else begin
      start_count_s = {1'b0, bus.io_count};
    end
`ifdef CARD_PUNCH_PREFETCH_EN
    // More bytes are still owed than the current word can supply; the gap
    // between remaining and bytes-left-in-hold does not change on a handshake.
    need_more_s = (remaining_r > (9'd4 - {7'd0, byte_idx_r}));
`endif
  end

  // Device state machine: CPU control, memory fetch and byte serializer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      address_r    <= 17'd0;
      hold_r       <= 32'd0;
      byte_idx_r   <= 2'd0;
      remaining_r  <= 9'd0;
      done_r       <= 1'b0;
      running_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 8'h00;
      cc_r         <= 4'b0000;
`ifdef CARD_PUNCH_PREFETCH_EN
      next_r       <= 32'd0;
      next_valid_r <= 1'b0;
`endif
    end else begin
      // Condition code: sio has priority over tio, and a busy device rejects sio.
      if (bus.sio) begin
        if (state_r == ST_IDLE) begin
          cc_r <= 4'b0000;
        end else begin
          cc_r <= 4'b1100;
        end
      end else if (bus.tio) begin
        cc_r <= {busy_s, 1'b0, done_r, 1'b0};
      end else begin
        cc_r <= cc_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (bus.sio) begin
            address_r   <= bus.io_address;
            remaining_r <= start_count_s;
            done_r      <= 1'b0;
            running_r   <= 1'b1;
            state_r     <= ST_FETCH;
`ifdef CARD_PUNCH_PREFETCH_EN
            next_valid_r <= 1'b0;
`endif
          end
        end

        ST_FETCH: begin
          if (grant_s) begin
            hold_r      <= bus.memory_data_in;
            address_r   <= address_r + 17'd1;
            byte_idx_r  <= 2'd0;
            out_data_r  <= byte_sel(bus.memory_data_in, 2'd0);
            out_valid_r <= 1'b1;
            running_r   <= 1'b0;
            state_r     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
`ifdef CARD_PUNCH_PREFETCH_EN
          // Background fetch into the spare word register. The request is
          // raised one cycle after the buffer empties, which still leaves the
          // remaining bytes of the current word to cover grant latency.
          if (grant_s) begin
            next_r       <= bus.memory_data_in;
            next_valid_r <= 1'b1;
            address_r    <= address_r + 17'd1;
            running_r    <= 1'b0;
          end else if (!running_r && !next_valid_r && need_more_s) begin
            running_r <= 1'b1;
          end
`endif
          if (handshake_s) begin
            remaining_r <= remaining_r - 9'd1;
            if (last_s) begin
              // Trailing bytes of a partial last word are dropped here.
              done_r      <= 1'b1;
              out_valid_r <= 1'b0;
              out_data_r  <= 8'h00;
              running_r   <= 1'b0;
              state_r     <= ST_IDLE;
`ifdef CARD_PUNCH_PREFETCH_EN
              next_valid_r <= 1'b0;
`endif
            end else if (byte_idx_r == 2'd3) begin
`ifdef CARD_PUNCH_PREFETCH_EN
              if (next_valid_r) begin
                hold_r       <= next_r;
                out_data_r   <= byte_sel(next_r, 2'd0);
                byte_idx_r   <= 2'd0;
                next_valid_r <= 1'b0;
              end else if (grant_s) begin
                // Word arrives on the very edge the last byte leaves: bypass
                // the spare register so the stream has no bubble.
                hold_r       <= bus.memory_data_in;
                out_data_r   <= byte_sel(bus.memory_data_in, 2'd0);
                byte_idx_r   <= 2'd0;
                next_valid_r <= 1'b0;
              end else begin
                out_valid_r <= 1'b0;
                out_data_r  <= 8'h00;
                running_r   <= 1'b1;
                state_r     <= ST_FETCH;
              end
`else
              out_valid_r <= 1'b0;
              out_data_r  <= 8'h00;
              running_r   <= 1'b1;
              state_r     <= ST_FETCH;
`endif
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
              out_data_r <= byte_sel(hold_r, byte_idx_r + 2'd1);
            end
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          running_r   <= 1'b0;
          out_valid_r <= 1'b0;
          out_data_r  <= 8'h00;
        end
      endcase
    end
  end

  assign bus.running   = running_r;
  assign bus.address   = address_r;
  assign bus.data_out  = 32'd0;
  assign bus.wr_en     = 4'b0000;
  assign bus.cc        = cc_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;

endmodule
